// File: rtl/blit_split_pkg.sv
// Shared blit definitions: default byte-address width, byte-lane select and
// the read-splitter state encoding. Also used by the byte-to-word write combiner.
package blit_split_pkg;

    localparam int unsigned BLIT_ADDR_W = 26;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        PREFETCH = 2'd2
    } blit_state_e;

    // Little-endian byte lane of a 32-bit word
    function automatic logic [7:0] blit_lane_sel(input logic [31:0] word,
                                                 input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/blit_split_if.sv
// Byte read request stream plus word memory read port of the blit splitter.
//   in_addr/in_en/in_active : byte read requests from the blit source pipeline
//   stall                   : combinational backpressure to the pipeline
//   out_data/out_valid      : returned byte, one pulse per accepted request
//   mem_req/mem_addr        : word-aligned memory read request
//   mem_ack/mem_rdata       : read completion with little-endian data
// slave  = splitter side, master = pipeline/memory environment side.
interface blit_split_if
    import blit_split_pkg::*;
#(
    parameter int unsigned ADDR_W = BLIT_ADDR_W
) ();

    logic [ADDR_W-1:0] in_addr;
    logic              in_en;
    logic              in_active;
    logic              stall;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport slave (
        input  in_addr, in_en, in_active, mem_ack, mem_rdata,
        output stall, out_data, out_valid, mem_req, mem_addr
    );

    modport master (
        output in_addr, in_en, in_active, mem_ack, mem_rdata,
        input  stall, out_data, out_valid, mem_req, mem_addr
    );

endinterface

// File: rtl/blit_word_buf.sv
// One-entry word buffer: tag, data and valid, with tag compare and byte select.
//   clk, rst_n              : clock, async active-low reset
//   lookup_tag, lane        : word address and byte lane of the current request
//   load_en/tag/data/valid  : write a fetched word (valid may be 0 to discard)
//   inval                   : clear valid (load takes priority)
//   valid                   : registered entry valid
//   match_c                 : combinational tag equality (qualify with valid)
//   byte_c                  : combinational selected byte of the stored word
module blit_word_buf
    import blit_split_pkg::*;
#(
    parameter int unsigned TAG_W = BLIT_ADDR_W - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic [1:0]       lane,
    input  logic             load_en,
    input  logic [TAG_W-1:0] load_tag,
    input  logic [31:0]      load_data,
    input  logic             load_valid,
    input  logic             inval,
    output logic             valid,
    output logic             match_c,
    output logic [7:0]       byte_c
);

    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      data_q, data_d;

    // Entry update
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (load_en) begin
            valid_d = load_valid;
            tag_d   = load_tag;
            data_d  = load_data;
        end else if (inval) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign valid   = valid_q;
    assign match_c = (lookup_tag == tag_q);
    assign byte_c  = blit_lane_sel(data_q, lane);

endmodule

// File: rtl/blit_split.sv
// Blit read splitter: serves byte reads from a buffered 32-bit word, fetching
// aligned words from memory on a miss and stalling the pipeline meanwhile.
//   clock, resetn : clock, async active-low reset
//   bus (slave)   : request stream, returned byte, memory read port
// Optional: BLIT_SPLIT_PREFETCH_EN adds a second buffer that is filled with the
// next sequential word in the background (PREFETCH state).
module blit_split
    import blit_split_pkg::*;
#(
    parameter int unsigned ADDR_W = BLIT_ADDR_W
) (
    input  logic        clock,
    input  logic        resetn,
    blit_split_if.slave bus
);

    localparam int unsigned WORD_W = ADDR_W - 2;

    blit_state_e       state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              discard_q, discard_d;

    logic [WORD_W-1:0] in_word_c, mem_word_c;
    logic [1:0]        lane_c;
    logic              req_c, hit_c, miss_c, stall_c, accept_c, load_valid_c;
    logic [7:0]        sel_byte_c;

    assign in_word_c    = bus.in_addr[ADDR_W-1:2];
    assign lane_c       = bus.in_addr[1:0];
    assign mem_word_c   = mem_addr_q[ADDR_W-1:2];
    assign req_c        = bus.in_en & bus.in_active;
    assign miss_c       = req_c & ~hit_c;
    assign accept_c     = req_c & ~stall_c;
    // A fetch completing after in_active dropped must not leave a valid entry
    assign load_valid_c = bus.in_active & ~discard_q;

`ifdef BLIT_SPLIT_PREFETCH_EN
    // Two physical buffers; pri_q names the one acting as primary, so a
    // promotion is a role swap rather than a data copy.
    logic              pri_q, pri_d, sec_c;
    logic [1:0]        b_valid, b_match, b_load, b_inval;
    logic [7:0]        b_byte [2];
    logic              prim_hit_c, pf_hit_c, pf_issue_c, promote_c;
    logic [WORD_W-1:0] next_word_c;

    for (genvar i = 0; i < 2; i++) begin : g_buf
        blit_word_buf #(.TAG_W(WORD_W)) u_buf (
            .clk        (clock),
            .rst_n      (resetn),
            .lookup_tag (in_word_c),
            .lane       (lane_c),
            .load_en    (b_load[i]),
            .load_tag   (mem_word_c),
            .load_data  (bus.mem_rdata),
            .load_valid (load_valid_c),
            .inval      (b_inval[i]),
            .valid      (b_valid[i]),
            .match_c    (b_match[i]),
            .byte_c     (b_byte[i])
        );
    end

    assign sec_c       = ~pri_q;
    assign next_word_c = in_word_c + WORD_W'(1);
    assign prim_hit_c  = b_valid[pri_q] & b_match[pri_q];
    assign pf_hit_c    = b_valid[sec_c] & b_match[sec_c];
    assign hit_c       = prim_hit_c | pf_hit_c;
    assign sel_byte_c  = prim_hit_c ? b_byte[pri_q] : b_byte[sec_c];
    // Prefetch is never in flight while FETCH is busy, so only FETCH stalls hits
    assign stall_c     = miss_c | (state_q == FETCH);
    // The secondary buffer, when valid, always holds primary word + 1:
    // it is cleared whenever the primary is replaced by a fetch or promotion.
    assign pf_issue_c  = accept_c & prim_hit_c & (state_q == IDLE) & ~b_valid[sec_c];
    assign promote_c   = accept_c & ~prim_hit_c;

    // Buffer load / invalidate steering
    always_comb begin
        b_load  = '0;
        b_inval = {2{~bus.in_active}};
        if (bus.mem_ack && (state_q == FETCH)) begin
            b_load[pri_q]  = 1'b1;
            b_inval[sec_c] = 1'b1;
        end
        if (bus.mem_ack && (state_q == PREFETCH)) begin
            b_load[sec_c] = 1'b1;
        end
        if (promote_c) begin
            b_inval[pri_q] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pri_q <= 1'b0;
        end else begin
            pri_q <= pri_d;
        end
    end

    always_comb begin
        pri_d = pri_q ^ promote_c;
    end
`else
    logic       buf_valid, buf_match, buf_load;
    logic [7:0] buf_byte;

    assign buf_load = (state_q == FETCH) & bus.mem_ack;

    blit_word_buf #(.TAG_W(WORD_W)) u_buf (
        .clk        (clock),
        .rst_n      (resetn),
        .lookup_tag (in_word_c),
        .lane       (lane_c),
        .load_en    (buf_load),
        .load_tag   (mem_word_c),
        .load_data  (bus.mem_rdata),
        .load_valid (load_valid_c),
        .inval      (~bus.in_active),
        .valid      (buf_valid),
        .match_c    (buf_match),
        .byte_c     (buf_byte)
    );

    assign hit_c      = buf_valid & buf_match;
    assign sel_byte_c = buf_byte;
    assign stall_c    = miss_c | (state_q != IDLE);
`endif

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (miss_c) begin
                    state_d = FETCH;
                end
`ifdef BLIT_SPLIT_PREFETCH_EN
                else if (pf_issue_c) begin
                    state_d = PREFETCH;
                end
`endif
            end
            default: begin
                if (bus.mem_ack) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Registered outputs and discard flag
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        out_valid_d = accept_c;
        out_data_d  = accept_c ? sel_byte_c : out_data_q;
        discard_d   = (state_q != IDLE) & ~bus.mem_ack & (discard_q | ~bus.in_active);
        case (state_q)
            IDLE: begin
                if (miss_c) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {in_word_c, 2'b00};
                end
`ifdef BLIT_SPLIT_PREFETCH_EN
                else if (pf_issue_c) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {next_word_c, 2'b00};
                end
`endif
            end
            default: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            discard_q   <= 1'b0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            discard_q   <= discard_d;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_blit_split.sv
// Scoreboard bench for blit_split: directed reads push expected bytes, a
// monitor pops on every out_valid; a memory responder with programmable wait.
// Build with BLIT_SPLIT_PREFETCH_EN to run the prefetch sequence instead.
module tb_blit_split;

    logic clk;
    logic rst_n;

    blit_split_if #(.ADDR_W(26)) bus ();

    blit_split #(.ADDR_W(26)) dut (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_fail;
    logic [7:0]  exp_q [$];
    logic [7:0]  mon_exp;
    int          mem_wait;
    bit          discard_mode;
    int          req_count;
    logic [25:0] last_addr;
    int          addr_moved;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory word contents: byte at address a is a[7:0], with two named words
    function automatic logic [31:0] mem_model(input logic [25:0] a);
        logic [7:0] b;
        b = a[7:0];
        if (discard_mode) return 32'hDEAD_BEEF;
        case (a)
            26'h100: return 32'h4433_2211;
            26'h104: return 32'h8877_6655;
            default: return {b + 8'd3, b + 8'd2, b + 8'd1, b};
        endcase
    endfunction

    // Memory responder: acks after mem_wait extra cycles of mem_req
    initial begin
        int  wait_cnt;
        bit  busy;
        bit  acked;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        wait_cnt = 0;
        busy     = 1'b0;
        acked    = 1'b0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_req !== 1'b1) begin
                busy     = 1'b0;
                acked    = 1'b0;
                wait_cnt = 0;
            end else begin
                if (!busy) begin
                    busy      = 1'b1;
                    req_count++;
                    last_addr = bus.mem_addr;
                end else if (bus.mem_addr !== last_addr) begin
                    addr_moved++;
                end
                if (!acked) begin
                    if (wait_cnt == mem_wait) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = mem_model(bus.mem_addr);
                        acked         = 1'b1;
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    // Output monitor
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_valid: got data %h expected no output at %0t",
                         bus.out_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.out_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL out_data: got %h expected %h at %0t",
                             bus.out_data, mon_exp, $time);
                end
            end
        end
    end

    // Issue one read at a negedge; hold until accepted; return at next negedge
    task automatic rd(input logic [25:0] a, input logic [7:0] e, input int exp_stalls);
        int stalls;
        bus.in_addr = a;
        bus.in_en   = 1'b1;
        stalls      = 0;
        #1;
        while (bus.stall && stalls < 50) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (bus.stall) begin
            n_vec++;
            n_fail++;
            $display("FAIL rd_timeout: addr %h still stalled after %0d cycles, expected accept",
                     a, stalls);
        end else begin
            exp_q.push_back(e);
        end
        chk($sformatf("stall_cycles@%h", a), stalls, exp_stalls);
        @(negedge clk);
    endtask

    task automatic reset_checks();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_stall", bus.stall, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec         = 0;
        n_fail        = 0;
        mem_wait      = 0;
        discard_mode  = 1'b0;
        req_count     = 0;
        last_addr     = '0;
        addr_moved    = 0;
        rst_n         = 1'b0;
        bus.in_addr   = '0;
        bus.in_en     = 1'b0;
        bus.in_active = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.in_active = 1'b1;

`ifdef BLIT_SPLIT_PREFETCH_EN
        rd(26'h200, 8'h00, 2);
        chk("pf_req_during_201", bus.mem_req, 1);
        chk("pf_addr_during_201", bus.mem_addr, 32'h204);
        rd(26'h201, 8'h01, 0);
        rd(26'h202, 8'h02, 0);
        rd(26'h203, 8'h03, 0);
        rd(26'h204, 8'h04, 0);
        rd(26'h205, 8'h05, 0);
        rd(26'h206, 8'h06, 0);
        rd(26'h207, 8'h07, 0);
        bus.in_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("pf_req_count", req_count, 3);
        chk("pf_last_addr", last_addr, 32'h208);
        bus.in_active = 1'b0;
        @(negedge clk);
        bus.in_active = 1'b1;
        rd(26'h200, 8'h00, 2);
        bus.in_en = 1'b0;
        @(negedge clk);
        chk("pf_req_count_after_inval", req_count, 5);
`else
        // Miss, zero-wait memory: 2 stall cycles, out_valid ack cycle + 2
        rd(26'h100, 8'h11, 2);
        chk("fill_req_count", req_count, 1);
        chk("fill_addr", last_addr, 32'h100);
        // Sequential hits within the word
        rd(26'h101, 8'h22, 0);
        rd(26'h102, 8'h33, 0);
        rd(26'h103, 8'h44, 0);
        chk("hits_no_req", req_count, 1);
        // Next word, zero wait
        rd(26'h104, 8'h55, 2);
        chk("next_word_addr", last_addr, 32'h104);
        rd(26'h107, 8'h88, 0);
        // Five wait states
        mem_wait = 5;
        rd(26'h10A, 8'h0A, 7);
        chk("wait5_addr", last_addr, 32'h108);
        mem_wait = 0;
        rd(26'h100, 8'h11, 2);
        chk("refetch_req_count", req_count, 4);

        // in_active drop during FETCH: data discarded
        mem_wait      = 3;
        discard_mode  = 1'b1;
        bus.in_addr   = 26'h104;
        bus.in_en     = 1'b1;
        #1;
        chk("discard_stall_miss", bus.stall, 1);
        @(negedge clk);
        bus.in_active = 1'b0;
        bus.in_en     = 1'b0;
        #1;
        chk("discard_stall_held", bus.stall, 1);
        for (int k = 0; k < 20 && bus.mem_req === 1'b1; k++) @(negedge clk);
        chk("discard_req_done", bus.mem_req, 0);
        chk("discard_req_count", req_count, 5);
        chk("discard_addr", last_addr, 32'h104);
        discard_mode  = 1'b0;
        mem_wait      = 0;
        bus.in_active = 1'b1;
        rd(26'h104, 8'h55, 2);
        chk("after_discard_refetch", req_count, 6);

        // in_active low while idle: no accept, buffer invalidated
        bus.in_active = 1'b0;
        bus.in_addr   = 26'h106;
        bus.in_en     = 1'b1;
        #1;
        chk("inactive_no_stall", bus.stall, 0);
        repeat (2) @(negedge clk);
        bus.in_active = 1'b1;
        rd(26'h106, 8'h77, 2);
        chk("inactive_refetch", req_count, 7);

        // Async reset in the middle of a long fetch
        mem_wait    = 20;
        bus.in_addr = 26'h10C;
        bus.in_en   = 1'b1;
        @(negedge clk);
        chk("midfetch_req", bus.mem_req, 1);
        chk("midfetch_addr", bus.mem_addr, 32'h10C);
        bus.in_en = 1'b0;
        rst_n     = 1'b0;
        #1;
        reset_checks();
        @(negedge clk);
        rst_n    = 1'b1;
        mem_wait = 0;
        rd(26'h100, 8'h11, 2);
        chk("post_reset_addr", last_addr, 32'h100);
`endif

        bus.in_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("mem_addr_stable", addr_moved, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/blit_split.md
Name: blit_split

Overview:
- Read-side counterpart of the blitter's byte-to-word write combiner.
- Takes a stream of byte read requests from the blit source pipeline and fetches aligned 32-bit words from memory.
- Holds the last fetched word in a one-entry buffer and returns the addressed byte.
- Stalls the pipeline on a buffer miss, so sequential byte reads within a word cost one memory read.

Parameters:
- ADDR_W, 26, byte address width; word address is ADDR_W-2 bits.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- in_addr  in  ADDR_W  byte address of read request
- in_en  in  1  read request valid; held with in_addr stable while stall=1
- in_active  in  1  blit in progress; low invalidates buffer
- stall  out  1  combinational; upstream must hold request
- out_data  out  8  returned byte, registered
- out_valid  out  1  out_data valid this cycle (single-cycle pulse per accepted request)
- mem_req  out  1  memory read request, registered
- mem_addr  out  ADDR_W  word-aligned read address, low 2 bits always 0
- mem_ack  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  32  read data, little-endian

Behaviour:
- Reset (resetn=0, async): buf_valid=0, state=IDLE, mem_req=0, mem_addr=0, out_valid=0, out_data=0. Buffer tag and data are cleared to 0.
- Byte select:
  - in_addr[1:0]=0 gives data[7:0]; 1 gives [15:8]; 2 gives [23:16]; 3 gives [31:24].
- hit = buf_valid & (in_addr[ADDR_W-1:2]==buf_tag).
- stall = (in_en & in_active & ~hit) | (state!=IDLE).
- Request accepted when in_en & in_active & ~stall.
- On acceptance at edge N: out_data = selected byte, out_valid=1 during cycle N+1. Hit latency is 1 cycle. Back-to-back hits sustain 1 byte/cycle.
- States:
  - IDLE: on in_en & in_active & ~hit, go to FETCH at the edge. Set mem_req=1 and mem_addr={in_addr[ADDR_W-1:2],2'b0}.
  - FETCH: mem_req and mem_addr are held constant until mem_ack. On mem_ack:
    - load buffer with mem_rdata;
    - tag = mem_addr word;
    - buf_valid=1 unless a discard is pending;
    - mem_req=0;
    - go to IDLE.
  - The held request then hits on the following cycle. Miss-to-out_valid latency = ack cycle + 2.
- mem_ack while in IDLE is ignored.
- mem_ack in the same cycle mem_req first rises is legal: a zero-wait-state memory acks on the first cycle mem_req=1.
- in_active=0:
  - buf_valid cleared at next edge; no new request accepted; out_valid=0.
  - If in FETCH, the transaction runs to mem_ack. The data is discarded (discard flag) and buf_valid stays 0.
  - stall stays 1 until FETCH exits.
- in_en=0 while IDLE: no change; out_valid=0 next cycle.
- Address wrap: word address compare is full width; no special wrap handling.
- Async reset mid-FETCH: mem_req drops immediately. The memory side must tolerate an abandoned request.

Optional Feature:
- BLIT_SPLIT_PREFETCH_EN
- Defined:
  - A second buffer holds the next sequential word.
  - On acceptance of a request whose word is the primary buffer word, if the prefetch buffer is not valid for word+1 and state=IDLE, issue mem_req for word+1 in PREFETCH state without stalling.
  - A request hitting the prefetch buffer promotes it to primary in the same edge as it is served.
  - A miss on both buffers while in PREFETCH stalls until that ack, then behaves as IDLE.
  - in_active=0 invalidates both buffers.
- Undefined: a single buffer, exactly as above, and the PREFETCH state does not exist.

Decomposition:
- Shared blit package:
  - ADDR_W default;
  - byte-lane select function (lane index to 32-bit slice), shared with the write combiner;
  - state enum (IDLE, FETCH, PREFETCH).
- One natural sub-module: blit_word_buf, holding tag, data and valid, with a hit compare and byte select. It is instantiated twice when prefetch is enabled.

Test Plan:
- Reset, then in_active=1, in_en with addr 0x100: stall=1; mem_req=1, mem_addr=0x100. Ack with rdata 0x44332211; out_data=0x11 with out_valid two cycles after the ack.
- Sequential addrs 0x101,0x102,0x103 after that fill: no stall, no mem_req; out_data 0x22,0x33,0x44 on consecutive cycles.
- Addr 0x104 (next word): new fetch with mem_addr=0x104 and stall held until the ack. The wait of 0 cycles (ack on first mem_req cycle) and of 5 cycles both give correct data.
- Drop in_active during FETCH, ack with 0xDEADBEEF, then reassert in_active and read 0x104: a new fetch is issued, because the discarded data was not buffered.
- Assert resetn=0 mid-FETCH: mem_req, out_valid and stall drop immediately. After release the first read at 0x100 misses.
- With BLIT_SPLIT_PREFETCH_EN: read 0x200..0x207 with one-cycle memory. Only the first access stalls, and mem_req for 0x204 is issued while 0x201 is served.
